// File: rtl/space_inv_pkg.sv
`default_nettype none
// =============================================================================
// Module : space_inv_pkg
// Brief  : Shared types and constants for the alien bomb logic.
// Rev    : 1.0 - initial release
// =============================================================================
package space_inv_pkg;

    localparam int NUM_BOMBS = 3;
    localparam int BOMB_LEN  = 3;

    localparam logic [3:0] BOMB_COLOUR  = 4'b1111;
    localparam logic [3:0] BLANK_COLOUR = 4'b0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FALLING = 2'd1,
        HIT     = 2'd2
    } bomb_state_t;

    // Population count of bombs striking the player in one cycle (0..NUM_BOMBS).
    function automatic logic [1:0] count_hits(input logic [NUM_BOMBS-1:0] hits);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            n = n + {1'b0, hits[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alien_bomb_if.sv
`default_nettype none
// =============================================================================
// Module : alien_bomb_if
// Brief  : Launch request / status bundle between game control and bombs.
// Rev    : 1.0 - initial release
// =============================================================================
interface alien_bomb_if;
    import space_inv_pkg::*;

    logic [NUM_BOMBS-1:0] fire_req;
    logic [11:0]          fire_row;
    logic [11:0]          fire_col;
    logic [NUM_BOMBS-1:0] bomb_busy;
    logic                 player_hit;
    logic [7:0]           hit_count;

    modport master (
        output fire_req, fire_row, fire_col,
        input  bomb_busy, player_hit, hit_count
    );

    modport slave (
        input  fire_req, fire_row, fire_col,
        output bomb_busy, player_hit, hit_count
    );

endinterface
`default_nettype wire

// File: rtl/bomb_channel.sv
`default_nettype none
// =============================================================================
// Module : bomb_channel
// Brief  : One bomb: launch/fall/hit state machine, position and pixel decode.
// Rev    : 1.0 - initial release
// =============================================================================
module bomb_channel
    import space_inv_pkg::*;
#(
    parameter int BOMB_STEP = 2,
    parameter int FLOOR_ROW = 470
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_tick,
    input  wire logic        i_fire,
    input  wire logic [11:0] i_fire_row,
    input  wire logic [11:0] i_fire_col,
    input  wire logic [11:0] i_pixel_row,
    input  wire logic [11:0] i_pixel_column,
    input  wire logic        i_player_active,
    output logic             o_active,
    output logic             o_busy,
    output logic             o_collide
);

    bomb_state_t r_state;
    logic [11:0] r_row;
    logic [11:0] r_col;
    logic        r_busy;

    logic [12:0] w_row_ext;
    logic [12:0] w_row_end;
    logic [12:0] w_row_next;
    logic        w_active;
    logic        w_collide;

    // 13-bit sums so a bomb near row 4095 cannot wrap into a false match.
    assign w_row_ext  = {1'b0, r_row};
    assign w_row_end  = w_row_ext + 13'(BOMB_LEN + 1);
    assign w_row_next = w_row_ext + 13'(BOMB_STEP);

    assign w_active  = (r_state == FALLING)
                    && ({1'b0, i_pixel_row} > w_row_ext)
                    && ({1'b0, i_pixel_row} < w_row_end)
                    && (i_pixel_column == r_col);
    assign w_collide = w_active && i_player_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fire) begin
                        r_state <= FALLING;
                        r_row   <= i_fire_row;
                        r_col   <= i_fire_col;
                        r_busy  <= 1'b1;
                    end
                end
                FALLING: begin
                    if (w_collide) begin
                        r_state <= HIT;
                    end else if (i_tick) begin
                        if (w_row_next > 13'(FLOOR_ROW)) begin
                            r_state <= IDLE;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_row <= w_row_next[11:0];
                        end
                    end
                end
                HIT: begin
                    if (i_tick) begin
                        r_state <= IDLE;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_active  = w_active;
    assign o_busy    = r_busy;
    assign o_collide = w_collide;

endmodule
`default_nettype wire

// File: rtl/alien_bomb.sv
`default_nettype none
// =============================================================================
// Module : alien_bomb
// Brief  : Alien bomb array with shared motion timer, hit tally and colour mux.
// Rev    : 1.0 - initial release
// =============================================================================
module alien_bomb
    import space_inv_pkg::*;
#(
    parameter int MOTION_TICKS = 1000000,
    parameter int BOMB_STEP    = 2,
    parameter int FLOOR_ROW    = 470
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [11:0]          pixel_row,
    input  wire logic [11:0]          pixel_column,
    input  wire logic                 player_active,
    output logic [NUM_BOMBS-1:0]      bomb_active,
    output logic [3:0]                bomb_output,
    alien_bomb_if.slave               bus
);

    localparam int CNT_W = (MOTION_TICKS > 1) ? $clog2(MOTION_TICKS) : 1;

    logic [CNT_W-1:0]     r_motion_cnt;
    logic                 r_player_hit;
    logic [7:0]           r_hit_count;

    logic                 w_tick;
    logic [NUM_BOMBS-1:0] w_busy;
    logic [NUM_BOMBS-1:0] w_collide;
    logic [1:0]           w_new_hits;
    logic [8:0]           w_hit_sum;

    assign w_tick = (r_motion_cnt == CNT_W'(MOTION_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_motion_cnt <= '0;
        end else begin
            r_motion_cnt <= r_motion_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_BOMBS; gi++) begin : g_bomb
        bomb_channel #(
            .BOMB_STEP (BOMB_STEP),
            .FLOOR_ROW (FLOOR_ROW)
        ) u_channel (
            .clk             (clk),
            .rst             (rst),
            .i_tick          (w_tick),
            .i_fire          (bus.fire_req[gi]),
            .i_fire_row      (bus.fire_row),
            .i_fire_col      (bus.fire_col),
            .i_pixel_row     (pixel_row),
            .i_pixel_column  (pixel_column),
            .i_player_active (player_active),
            .o_active        (bomb_active[gi]),
            .o_busy          (w_busy[gi]),
            .o_collide       (w_collide[gi])
        );
    end

    // Simultaneous strikes give one pulse but each bomb adds to the tally.
    assign w_new_hits = count_hits(w_collide);
    assign w_hit_sum  = {1'b0, r_hit_count} + {7'd0, w_new_hits};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_player_hit <= 1'b0;
            r_hit_count  <= '0;
        end else begin
            r_player_hit <= |w_collide;
            r_hit_count  <= w_hit_sum[8] ? 8'hFF : w_hit_sum[7:0];
        end
    end

    assign bomb_output    = (|bomb_active) ? BOMB_COLOUR : BLANK_COLOUR;
    assign bus.bomb_busy  = w_busy;
    assign bus.player_hit = r_player_hit;
    assign bus.hit_count  = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_alien_bomb.sv
`default_nettype none
// =============================================================================
// Module : tb_alien_bomb
// Brief  : Directed self-checking bench for alien_bomb with a behavioural model.
// Rev    : 1.0 - initial release
// =============================================================================
module tb_alien_bomb;

    localparam int MT    = 4;
    localparam int STEP  = 2;
    localparam int FLOOR = 470;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_row = '0;
    logic [11:0] pixel_column = '0;
    logic        player_active = 1'b0;
    logic [2:0]  bomb_active;
    logic [3:0]  bomb_output;

    alien_bomb_if bus ();

    alien_bomb #(
        .MOTION_TICKS (MT),
        .BOMB_STEP    (STEP),
        .FLOOR_ROW    (FLOOR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_row     (pixel_row),
        .pixel_column  (pixel_column),
        .player_active (player_active),
        .bomb_active   (bomb_active),
        .bomb_output   (bomb_output),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: 0 idle, 1 falling, 2 struck ----------
    int m_state [3];
    int m_row   [3];
    int m_col   [3];
    int m_cyc;
    int exp_count;
    bit exp_hit;
    bit m_valid = 1'b0;
    bit m_ticked = 1'b0;

    function automatic bit covers(input int i);
        return (m_state[i] == 1) && (int'(pixel_row) > m_row[i])
            && (int'(pixel_row) < m_row[i] + 4) && (int'(pixel_column) == m_col[i]);
    endfunction

    always @(posedge clk) begin
        bit tick;
        int n;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_state[i] = 0; m_row[i] = 0; m_col[i] = 0;
            end
            m_cyc = 0; exp_count = 0; exp_hit = 0; m_ticked = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            tick = ((m_cyc % MT) == MT - 1);
            m_ticked = tick;
            m_cyc++;
            n = 0;
            for (int i = 0; i < 3; i++) begin
                if (m_state[i] == 1 && covers(i) && player_active) begin
                    m_state[i] = 2; n++;
                end else if (m_state[i] == 1 && tick) begin
                    if (m_row[i] + STEP > FLOOR) begin
                        m_state[i] = 0; m_row[i] = 0; m_col[i] = 0;
                    end else begin
                        m_row[i] = m_row[i] + STEP;
                    end
                end else if (m_state[i] == 2 && tick) begin
                    m_state[i] = 0; m_row[i] = 0; m_col[i] = 0;
                end else if (m_state[i] == 0 && bus.fire_req[i]) begin
                    m_state[i] = 1;
                    m_row[i] = int'(bus.fire_row);
                    m_col[i] = int'(bus.fire_col);
                end
            end
            exp_hit = (n > 0);
            exp_count = (exp_count + n > 255) ? 255 : exp_count + n;
        end
    end

    always @(negedge clk) begin
        int ea;
        int eb;
        if (m_valid) begin
            ea = 0; eb = 0;
            for (int i = 0; i < 3; i++) begin
                if (covers(i)) ea = ea | (1 << i);
                if (m_state[i] != 0) eb = eb | (1 << i);
            end
            chk("bomb_active", int'(bomb_active), ea);
            chk("bomb_output", int'(bomb_output), (ea != 0) ? 15 : 0);
            chk("bomb_busy", int'(bus.bomb_busy), eb);
            chk("player_hit", int'(bus.player_hit), int'(exp_hit));
            chk("hit_count", int'(bus.hit_count), exp_count);
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic fire(input logic [2:0] mask, input int row, input int col);
        bus.fire_req = mask;
        bus.fire_row = 12'(row);
        bus.fire_col = 12'(col);
        cyc();
        bus.fire_req = '0;
    endtask

    task automatic pix(input int r, input int c, input logic p);
        pixel_row = 12'(r);
        pixel_column = 12'(c);
        player_active = p;
    endtask

    task automatic wait_motion();
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!m_ticked && k < 10);
        if (!m_ticked) begin
            checks++; failures++;
            $display("FAIL motion_wait: no tick within %0d cycles", k);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.bomb_busy != 3'b000 && k < 20) begin
            cyc();
            k++;
        end
        if (bus.bomb_busy != 3'b000) begin
            checks++; failures++;
            $display("FAIL idle_wait: busy=%b after %0d cycles", bus.bomb_busy, k);
        end
    endtask

    task automatic hit_round(input logic [2:0] mask);
        fire(mask, 200, 40);
        pix(201, 40, 1'b1);
        cyc();
        pix(0, 0, 1'b0);
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fire_req = '0;
        bus.fire_row = '0;
        bus.fire_col = '0;
        rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_busy", int'(bus.bomb_busy), 0);
        chk("rst_hit_count", int'(bus.hit_count), 0);
        chk("rst_player_hit", int'(bus.player_hit), 0);
        rst = 1'b0;

        // launch and fall two steps
        fire(3'b001, 100, 200);
        @(negedge clk);
        chk("fire_busy", int'(bus.bomb_busy), 1);
        wait_motion();
        pix(103, 200, 1'b0);
        @(negedge clk);
        chk("row102_active", int'(bomb_active), 1);
        chk("row102_colour", int'(bomb_output), 15);
        cyc();
        pix(102, 200, 1'b0);
        @(negedge clk);
        chk("row102_top_edge", int'(bomb_active), 0);
        wait_motion();
        pix(105, 200, 1'b0);
        @(negedge clk);
        chk("row104_active", int'(bomb_active), 1);
        pix(0, 0, 1'b0);

        // floor boundary
        rst = 1'b1; cyc(); rst = 1'b0;
        fire(3'b001, 468, 10);
        wait_motion();
        pix(471, 10, 1'b0);
        @(negedge clk);
        chk("row470_active", int'(bomb_active), 1);
        wait_motion();
        pix(0, 0, 1'b0);
        @(negedge clk);
        chk("floor_idle", int'(bus.bomb_busy), 0);
        chk("floor_no_hit", int'(bus.player_hit), 0);

        // re-fire ignored while falling, reset beats fire
        rst = 1'b1; cyc(); rst = 1'b0;
        fire(3'b001, 150, 50);
        fire(3'b001, 10, 99);
        pix(153, 50, 1'b0);
        @(negedge clk);
        chk("refire_keep", int'(bomb_active), 1);
        cyc();
        pix(11, 99, 1'b0);
        @(negedge clk);
        chk("refire_ignored", int'(bomb_active), 0);
        rst = 1'b1;
        bus.fire_req = 3'b001; bus.fire_row = 12'd20; bus.fire_col = 12'd20;
        cyc();
        rst = 1'b0;
        bus.fire_req = '0;
        @(negedge clk);
        chk("rst_beats_fire", int'(bus.bomb_busy), 0);

        // single collision
        fire(3'b001, 300, 320);
        pix(302, 320, 1'b1);
        @(negedge clk);
        chk("collide_active", int'(bomb_active), 1);
        cyc();
        pix(0, 0, 1'b0);
        @(negedge clk);
        chk("hit_pulse", int'(bus.player_hit), 1);
        chk("hit_count1", int'(bus.hit_count), 1);
        chk("hit_busy", int'(bus.bomb_busy), 1);
        cyc();
        @(negedge clk);
        chk("hit_pulse_once", int'(bus.player_hit), 0);
        wait_idle();

        // dual collision
        fire(3'b011, 300, 320);
        pix(302, 320, 1'b1);
        cyc();
        pix(0, 0, 1'b0);
        @(negedge clk);
        chk("dual_pulse", int'(bus.player_hit), 1);
        chk("dual_count", int'(bus.hit_count), 3);
        cyc();
        @(negedge clk);
        chk("dual_once", int'(bus.player_hit), 0);
        wait_idle();

        // saturation
        for (int r = 0; r < 83; r++) hit_round(3'b111);
        @(negedge clk);
        chk("grind_count", int'(bus.hit_count), 252);
        hit_round(3'b011);
        @(negedge clk);
        chk("count254", int'(bus.hit_count), 254);
        hit_round(3'b011);
        @(negedge clk);
        chk("saturate", int'(bus.hit_count), 255);
        hit_round(3'b001);
        @(negedge clk);
        chk("saturate_hold", int'(bus.hit_count), 255);

        // reset mid-flight, then motion counter phase after reset
        fire(3'b100, 50, 60);
        pix(51, 60, 1'b0);
        @(negedge clk);
        chk("pre_rst_active", int'(bomb_active), 4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.fire_req = 3'b100; bus.fire_row = 12'd50; bus.fire_col = 12'd60;
        @(negedge clk);
        chk("rst_flight_busy", int'(bus.bomb_busy), 0);
        chk("rst_flight_active", int'(bomb_active), 0);
        chk("rst_flight_count", int'(bus.hit_count), 0);
        chk("rst_flight_hit", int'(bus.player_hit), 0);
        cyc();
        bus.fire_req = '0;
        cyc(); cyc();
        @(negedge clk);
        chk("cnt_phase_pre", int'(bomb_active), 4);
        cyc();
        @(negedge clk);
        chk("cnt_phase_tick", int'(bomb_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
